// File: rtl/if_stage_pkg.sv
// Shared fetch-side definitions: bus widths, chip-enable levels, IF/ID payload
// and the IF/ID update operations selected by the fetch stage.
package if_stage_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  localparam logic [INST_W-1:0]      ZERO_WORD        = '0;
  localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } if_id_t;

  typedef enum logic [1:0] {
    IFID_HOLD,
    IFID_BUBBLE,
    IFID_CLEAR,
    IFID_CAPTURE
  } if_id_op_e;

  // Redirect targets are always word aligned.
  function automatic inst_addr_t word_align(input inst_addr_t addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID boundary register: applies the hold/bubble/clear/capture operation
// chosen by the fetch stage and counts delivered instructions.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  if_id_op_e              op,
  input  if_id_t                 fetch,
  output logic [INST_ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0]      id_inst,
  output logic                   id_valid,
  output logic [31:0]            fetch_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc     <= '0;
      id_inst   <= ZERO_WORD;
      id_valid  <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      case (op)
        IFID_CLEAR: begin
          id_pc    <= '0;
          id_inst  <= ZERO_WORD;
          id_valid <= 1'b0;
        end
        // A bubble keeps the last id_pc; only the instruction is voided.
        IFID_BUBBLE: begin
          id_inst  <= ZERO_WORD;
          id_valid <= 1'b0;
        end
        IFID_CAPTURE: begin
          id_pc     <= fetch.pc;
          id_inst   <= fetch.inst;
          id_valid  <= 1'b1;
          fetch_cnt <= fetch_cnt + 32'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and ROM enable, selects the next PC and
// steers the IF/ID register through wake-up, stalls, branches and flushes.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned            PC_STEP    = 4,
  parameter bit                     DELAY_SLOT = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_if,
  input  logic                   stall_id,
  input  logic                   branch_flag_in,
  input  logic [INST_ADDR_W-1:0] branch_target_in,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] new_pc,
  input  logic [INST_W-1:0]      inst_in,
  output logic                   rom_en_out,
  output logic [INST_ADDR_W-1:0] pc_out,
  output logic [INST_ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0]      id_inst,
  output logic                   id_valid,
  output logic [31:0]            fetch_cnt
);

  typedef enum logic {
    ST_WAKE,
    ST_RUN
  } state_e;

  state_e    state;
  if_id_op_e if_id_op;
  if_id_t    fetch;

  assign fetch = {pc_out, inst_in};

  // IF/ID operation; a stalled decode wins over a stalled fetch, flush over both.
  always_comb begin
    if_id_op = IFID_HOLD;
    if (state == ST_RUN) begin
      if (flush)               if_id_op = IFID_CLEAR;
      else if (stall_id)       if_id_op = IFID_HOLD;
      else if (stall_if)       if_id_op = IFID_BUBBLE;
      else if (branch_flag_in) if_id_op = DELAY_SLOT ? IFID_CAPTURE : IFID_BUBBLE;
      else                     if_id_op = IFID_CAPTURE;
    end
  end

  // Enable FSM and PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_WAKE;
      rom_en_out <= CHIP_DISABLE;
      pc_out     <= RESET_PC;
    end else begin
      case (state)
        ST_WAKE: begin
          state      <= ST_RUN;
          rom_en_out <= CHIP_ENABLE;
        end
        ST_RUN: begin
          if (flush)                      pc_out <= word_align(new_pc);
          else if (stall_if || stall_id)  pc_out <= pc_out;
          else if (branch_flag_in)        pc_out <= word_align(branch_target_in);
          else                            pc_out <= pc_out + INST_ADDR_W'(PC_STEP);
        end
        default: begin
          state      <= ST_WAKE;
          rom_en_out <= CHIP_DISABLE;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .op        (if_id_op),
    .fetch     (fetch),
    .id_pc     (id_pc),
    .id_inst   (id_inst),
    .id_valid  (id_valid),
    .fetch_cnt (fetch_cnt)
  );

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage directly upstream of the instruction ROM. It owns the program counter and drives the ROM enable and address. It captures the ROM's combinational instruction word into a registered IF/ID boundary toward decode. It handles reset wake-up, pipeline stalls, branch redirects with an optional delay slot, and exception flushes.

Parameters:
RESET_PC, 32'h0000_0000, PC value held during reset and for the first fetch
PC_STEP, 4, byte increment per sequential fetch
DELAY_SLOT, 1, 1 = the instruction fetched alongside a taken branch proceeds to decode; 0 = it is squashed

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-high
stall_if  in  1  hold PC; no new fetch accepted this cycle
stall_id  in  1  hold the IF/ID register contents
branch_flag_in  in  1  taken branch or jump resolved in decode
branch_target_in  in  32  branch or jump target address
flush  in  1  exception or eret flush
new_pc  in  32  exception handler or return address, used with flush
inst_in  in  32  instruction word returned combinationally by the ROM
rom_en_out  out  1  ROM chip enable (chip_enable / chip_disable)
pc_out  out  32  ROM fetch address; equals the current PC
id_pc  out  32  PC of the instruction presented to decode
id_inst  out  32  instruction presented to decode
id_valid  out  1  id_inst is a real instruction, not a bubble
fetch_cnt  out  32  count of instructions delivered with id_valid=1

Behaviour:
- Reset (async, immediate): rom_en_out=0, pc_out=RESET_PC, id_pc=0, id_inst=zero_word, id_valid=0, fetch_cnt=0.
- While rom_en_out=0, inst_in is ignored.
- Wake-up states: WAKE → RUN.
  - First rising edge after rst falls: WAKE → RUN, rom_en_out←1, pc_out remains RESET_PC, and no instruction is captured.
  - The first capture into IF/ID happens at the following edge.
- In RUN, each edge evaluates the following in priority order:
  1. flush=1: pc_out←{new_pc[31:2],2'b00}; id_inst←zero_word, id_valid←0, id_pc←0. Stalls are ignored.
  2. stall_if=1 and stall_id=1: PC and IF/ID hold. branch_flag_in is ignored because decode re-presents it next cycle.
  3. stall_if=1 and stall_id=0: PC holds; a bubble enters ID (id_valid←0, id_inst←zero_word).
  4. stall_if=0 and stall_id=1: treated as case 2 (PC also holds).
  5. branch_flag_in=1: pc_out←{branch_target_in[31:2],2'b00}.
     - DELAY_SLOT=1: IF/ID captures {pc_out, inst_in} with id_valid←1.
     - DELAY_SLOT=0: IF/ID receives a bubble.
  6. Otherwise: IF/ID←{pc_out, inst_in}, id_valid←1; pc_out←pc_out+PC_STEP.
- Address rules:
  - pc_out is 32-bit and wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
  - The low 2 bits of every redirect target are forced to 0.
- Latency: the instruction at address A appears on id_inst one edge after pc_out=A, provided no stall or flush.
- fetch_cnt increments on every edge where id_valid is written 1 by case 5 or 6. It wraps at 2^32 and is unaffected by holds.
- Reset asserted mid-stream returns the block to the reset values and the WAKE state immediately, with no edge required.

Decomposition:
- defines.v (shared) holds: chip_enable/chip_disable, zero_word, inst_addr_bus/inst_bus widths, and the RESET_PC default macro.
- The WAKE/RUN encoding is local to if_stage.
- Natural sub-module: if_id_reg, which contains the IF/ID register, its hold/bubble/flush logic and fetch_cnt.
- if_stage keeps the PC, the next-PC mux and the enable FSM.

Test Plan:
- Reset release: rst 1→0, inst_in=32'h3401_0001 at address 0. Expected:
  - edge 1: rom_en_out=1, pc_out=0, id_valid=0;
  - edge 2: id_pc=0, id_inst=32'h3401_0001, id_valid=1, pc_out=4, fetch_cnt=1.
- Sequential fetch: 4 free-running cycles from pc 0 → pc_out 4, 8, 12, 16; id_pc trails pc_out by one edge; fetch_cnt=4.
- Stall: at pc_out=8, set stall_if=1, stall_id=0 for 1 cycle, then stall_if=1, stall_id=1 for 2 cycles. Expected:
  - pc_out stays 8 throughout;
  - first cycle gives id_valid=0;
  - the next two cycles hold id_valid=0;
  - after release, id_pc=8.
- Branch, DELAY_SLOT=1: at pc_out=16, branch_flag_in=1, target 32'h0000_0103. Expected pc_out=32'h0000_0100, id_pc=16, id_valid=1. With DELAY_SLOT=0, id_valid=0 instead.
- Flush over stall: stall_if=1, stall_id=1, flush=1, new_pc=32'h0000_0180 → pc_out=32'h180, id_valid=0, id_inst=0, fetch_cnt unchanged.
- Wrap and async reset:
  - flush to 32'hFFFF_FFFC, then one free cycle → pc_out=0.
  - assert rst between edges → all outputs return to reset values immediately.
